clk_divider_prog: RTL and testbench

Runtime-programmable clock divider that produces a 50%-duty output for both even and odd divisors. Odd divisors use a negative-edge flop. This block supersedes the fixed-parameter dual-edge divider and adds:
- a divisor register loaded at runtime,
- glitch-free divisor changes at period boundaries,
- an enable that stops the output cleanly,
- a period-start tick.

It sits next to the system clock root and feeds slow peripheral clocks and strobes.

---
 rtl/clk_divider_prog.sv | 138 +++++++++++++
 tb/tb_clk_divider_prog.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable clock divider with a 50% duty cycle
// for even and odd divisors. A negedge flop stretches the high phase by half
// a source cycle for odd divisors. Divisor changes take effect only at period
// boundaries, and dropping the enable always lets the current period finish.
module clk_divider_prog #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div,
    input  logic             div_load,
    output logic             out_clk,
    output logic             period_tick,
    output logic             running,
    output logic [WIDTH-1:0] div_cur,
    output logic             div_err
);

    localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DIV_MIN   = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_cur_q, div_cur_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic             out_pos_q, out_pos_d;
    logic             out_neg_q;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             load_ok;
    logic             load_bad;
    logic [WIDTH-1:0] pend_eff;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] half;
    logic             at_boundary;

    // Load qualification; a valid load in the current cycle bypasses div_pend
    always_comb begin
        load_ok     = div_load && (div >= DIV_MIN);
        load_bad    = div_load && (div < DIV_MIN);
        pend_eff    = load_ok ? div : div_pend_q;
        cnt_inc     = cnt_q + ONE;
        half        = div_cur_q >> 1;
        at_boundary = (state_q == S_RUN) && (cnt_q == (div_cur_q - ONE));
    end

    // Next-state and next-output logic for the IDLE/RUN controller
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        div_pend_d = pend_eff;
        out_pos_d  = out_pos_q;
        tick_d     = 1'b0;
        err_d      = load_bad;

        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                out_pos_d = 1'b0;
                div_cur_d = pend_eff;
                if (en) begin
                    state_d   = S_RUN;
                    out_pos_d = 1'b1;
                    tick_d    = 1'b1;
                end
            end
            S_RUN: begin
                if (at_boundary) begin
                    cnt_d     = '0;
                    div_cur_d = pend_eff;
                    if (en) begin
                        out_pos_d = 1'b1;
                        tick_d    = 1'b1;
                    end else begin
                        state_d   = S_IDLE;
                        out_pos_d = 1'b0;
                    end
                end else begin
                    cnt_d     = cnt_inc;
                    out_pos_d = (cnt_inc < half);
                end
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                out_pos_d = 1'b0;
            end
        endcase
    end

    // Posedge state, counter, divisor and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_cur_q  <= DIV_RESET;
            div_pend_q <= DIV_RESET;
            out_pos_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            out_pos_q  <= out_pos_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    // Half-cycle delayed copy of the high phase, used to stretch odd divisors
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_neg_q <= 1'b0;
        end else begin
            out_neg_q <= out_pos_q;
        end
    end

    // div_cur_q[0] only changes at a boundary while both phase flops are low
    assign out_clk     = out_pos_q | (div_cur_q[0] & out_neg_q);
    assign period_tick = tick_q;
    assign running     = (state_q == S_RUN);
    assign div_cur     = div_cur_q;
    assign div_err     = err_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog: the stimulus pushes the expected
// high time and period of every out_clk pulse; a monitor measures each pulse.
`timescale 1ns/1ps
module tb_clk_divider_prog;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] div;
    logic             div_load;
    logic             out_clk;
    logic             period_tick;
    logic             running;
    logic [WIDTH-1:0] div_cur;
    logic             div_err;

    typedef struct {
        longint high_ns;
        longint period_ns; // 0: next rise is not back-to-back, skip period check
    } pulse_t;

    pulse_t q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    clk_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div        (div),
        .div_load   (div_load),
        .out_clk    (out_clk),
        .period_tick(period_tick),
        .running    (running),
        .div_cur    (div_cur),
        .div_err    (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input longint high_ns, input longint period_ns);
        pulse_t p;
        p.high_ns   = high_ns;
        p.period_ns = period_ns;
        q.push_back(p);
    endtask

    task automatic load(input logic [WIDTH-1:0] value);
        div      = value;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
    endtask

    // Run n periods of divisor d from a negedge while idle; ends idle again
    task automatic run_periods(input int d, input int n);
        en = 1'b1;
        step((n - 1) * d + 1);
        en = 1'b0;
        step(d);
        check("stopped_running", longint'(running), 0);
        check("stopped_out_clk", longint'(out_clk), 0);
    endtask

    // Monitor: measure every out_clk pulse and compare against the scoreboard
    initial begin
        longint t_rise;
        longint t_fall;
        longint prev_rise;
        longint pend_period;
        pulse_t p;
        prev_rise   = 0;
        pend_period = 0;
        forever begin
            @(posedge out_clk);
            t_rise = $time;
            if (pend_period != 0)
                check("period_ns", t_rise - prev_rise, pend_period);
            check("rise_on_posedge", (t_rise - 5) % 10, 0);
            #1;
            check("tick_at_rise", longint'(period_tick), 1);
            check("running_at_rise", longint'(running), 1);
            #10;
            check("tick_one_cycle", longint'(period_tick), 0);
            @(negedge out_clk);
            t_fall = $time;
            if (q.size() == 0) begin
                check("unexpected_pulse_high_ns", t_fall - t_rise, 0);
                pend_period = 0;
            end else begin
                p = q.pop_front();
                check("high_ns", t_fall - t_rise, p.high_ns);
                pend_period = p.period_ns;
            end
            prev_rise = t_rise;
        end
    end

    // Directed stimulus
    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        div      = '0;
        div_load = 1'b0;

        // Reset values
        #12;
        check("rst_out_clk", longint'(out_clk), 0);
        check("rst_running", longint'(running), 0);
        check("rst_tick", longint'(period_tick), 0);
        check("rst_div_err", longint'(div_err), 0);
        check("rst_div_cur", longint'(div_cur), 8);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Default divisor 8: 80 ns period, 40 ns high
        push(40, 80); push(40, 80); push(40, 0);
        run_periods(8, 3);
        step(3);

        // Odd divisor 5 loaded while idle: 25 ns high, 50 ns period
        load(5);
        check("idle_load_div_cur", longint'(div_cur), 5);
        push(25, 50); push(25, 50); push(25, 0);
        run_periods(5, 3);
        step(3);

        // Mid-period change 8 -> 3 presented at cnt=2
        load(8);
        push(40, 80); push(15, 30); push(15, 30); push(15, 0);
        en = 1'b1;
        step(3);
        div      = 3;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        check("pend_not_applied_yet", longint'(div_cur), 8);
        step(5);
        check("pend_applied_at_boundary", longint'(div_cur), 3);
        step(6);
        en = 1'b0;
        step(3);
        check("s3_stopped_running", longint'(running), 0);
        check("s3_stopped_out_clk", longint'(out_clk), 0);
        step(3);

        // Enable drop at cnt=1 of a 6-period, then immediate re-enable
        load(6);
        push(30, 60); push(30, 0); push(30, 0);
        en = 1'b1;
        step(8);
        en = 1'b0;
        step(3);
        check("drop_period_completes", longint'(out_clk), 0);
        check("drop_still_running", longint'(running), 1);
        step(2);
        check("drop_running_low", longint'(running), 0);
        check("drop_out_clk_low", longint'(out_clk), 0);
        en = 1'b1;
        step(1);
        check("reenable_out_clk", longint'(out_clk), 1);
        check("reenable_running", longint'(running), 1);
        en = 1'b0;
        step(6);
        check("reenable_stopped", longint'(running), 0);
        step(2);

        // Invalid load: error pulse, divisor unchanged
        div      = 1;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        check("err_pulse", longint'(div_err), 1);
        check("err_div_cur_kept", longint'(div_cur), 6);
        step(1);
        check("err_one_cycle", longint'(div_err), 0);

        // Load of 4 exactly on the boundary edge of a 6-period
        push(30, 60); push(20, 40); push(20, 40); push(20, 0);
        en = 1'b1;
        step(6);
        div      = 4;
        div_load = 1'b1;
        step(1);
        div_load = 1'b0;
        check("bypass_div_cur", longint'(div_cur), 4);
        step(8);
        en = 1'b0;
        step(4);
        check("bypass_stopped", longint'(running), 0);
        step(2);

        // Async reset mid-high-phase of a divisor-7 period
        load(7);
        push(17, 0); push(40, 80); push(40, 0);
        en = 1'b1;
        #22;
        rst_n = 1'b0;
        #1;
        check("arst_out_clk", longint'(out_clk), 0);
        check("arst_running", longint'(running), 0);
        check("arst_tick", longint'(period_tick), 0);
        check("arst_div_err", longint'(div_err), 0);
        check("arst_div_cur", longint'(div_cur), 8);
        #1;
        rst_n = 1'b1;
        step(1);
        check("arst_restart", longint'(running), 1);
        step(8);
        en = 1'b0;
        step(8);
        check("arst_stopped", longint'(running), 0);
        step(3);

        check("scoreboard_drained", longint'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
